// File: rtl/sfifo_wr_arb.sv
// Two-port burst-locking write arbiter in front of a sync FIFO.
// Flow control is driven by a local credit counter.
module sfifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [WIDTH-1:0]           req0_data,
  input  logic                       req0_last,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [WIDTH-1:0]           req1_data,
  input  logic                       req1_last,
  output logic                       req1_ready,
  input  logic                       fifo_rd,
  output logic                       fifo_winc,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(DEPTH):0]     credit
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  state_t           state;
  logic             last_srv;
  logic             grant0;
  logic             grant1;
  logic             has_credit;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic             rd_eff;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  // Grants depend only on state and valids, never on ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | last_srv);
        grant1 = req1_valid & (~req0_valid | ~last_srv);
      end
      LOCK0: grant0 = 1'b1;
      LOCK1: grant1 = 1'b1;
      default: ;
    endcase
  end

  assign has_credit = (credit != '0);
  assign req0_ready = rst_n & grant0 & has_credit;
  assign req1_ready = rst_n & grant1 & has_credit;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;
  assign xfer       = xfer0 | xfer1;
  assign sel_data   = xfer1 ? req1_data : req0_data;
  assign sel_last   = xfer1 ? req1_last : req0_last;
  assign rd_eff     = fifo_rd & (credit != CW'(DEPTH));

  // Arbitration FSM: lock onto a port until its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_srv <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            last_srv <= xfer1;
            if (!sel_last) state <= xfer1 ? LOCK1 : LOCK0;
          end
        end
        LOCK0: if (xfer0 && req0_last) state <= IDLE;
        LOCK1: if (xfer1 && req1_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write strobe; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_winc  <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_winc <= xfer;
      if (xfer) fifo_wdata <= sel_data;
    end
  end

  // Free-slot counter; pops at full credit are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CW'(DEPTH);
    end else begin
      unique case ({xfer, rd_eff})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Directed bench for sfifo_wr_arb.
// Expected values are hand-computed per vector.
module tb_sfifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       fifo_rd, fifo_winc;
  logic [7:0] fifo_wdata;
  logic [4:0] credit;

  int n_cmp = 0;
  int n_bad = 0;
  int wc;

  sfifo_wr_arb #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .fifo_rd(fifo_rd), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .credit(credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0,
                       input logic l0, input logic v1,
                       input logic [7:0] d1, input logic l1);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
  endtask

  initial begin
    rst_n   = 1'b0;
    fifo_rd = 1'b0;
    drive(1, 8'h00, 1, 1, 8'h00, 1);
    #12;
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_credit", credit, 16);
    check("rst_winc", fifo_winc, 0);
    check("rst_wdata", fifo_wdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round robin ties 0,1,0,1
    drive(1, 8'h10, 1, 1, 8'h20, 1); #1;
    check("rr0_rdy0", req0_ready, 1);
    check("rr0_rdy1", req1_ready, 0);
    step;
    check("rr0_winc", fifo_winc, 1);
    check("rr0_wdata", fifo_wdata, 8'h10);
    check("rr0_credit", credit, 15);
    drive(1, 8'h11, 1, 1, 8'h21, 1); #1;
    check("rr1_rdy0", req0_ready, 0);
    check("rr1_rdy1", req1_ready, 1);
    step;
    check("rr1_wdata", fifo_wdata, 8'h21);
    check("rr1_credit", credit, 14);
    drive(1, 8'h12, 1, 1, 8'h22, 1); #1;
    check("rr2_rdy0", req0_ready, 1);
    step;
    check("rr2_wdata", fifo_wdata, 8'h12);
    drive(1, 8'h13, 1, 1, 8'h23, 1); #1;
    check("rr3_rdy1", req1_ready, 1);
    step;
    check("rr3_wdata", fifo_wdata, 8'h23);
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    step;
    check("rr_idle_winc", fifo_winc, 0);
    check("rr_hold_wdata", fifo_wdata, 8'h23);
    check("rr_credit", credit, 12);

    // port0 burst of 3 locks out port1
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h30 + 8'(k), k == 2, 1, 8'h40, 1); #1;
      check("lk_rdy0", req0_ready, 1);
      check("lk_rdy1", req1_ready, 0);
      step;
      check("lk_wdata", fifo_wdata, 8'h30 + k);
    end
    drive(1, 8'h33, 1, 1, 8'h40, 1); #1;
    check("lk4_rdy1", req1_ready, 1);
    check("lk4_rdy0", req0_ready, 0);
    step;
    check("lk4_wdata", fifo_wdata, 8'h40);
    check("lk4_credit", credit, 8);

    // fill to zero credit
    wc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 8'h50 + 8'(k), 1, 0, 8'h00, 0);
      step;
      wc += int'(fifo_winc);
    end
    check("fill_wcount", wc, 8);
    check("fill_credit", credit, 0);
    check("fill_wdata", fifo_wdata, 8'h57);
    drive(1, 8'h5a, 1, 1, 8'h5b, 1); #1;
    check("full_rdy0", req0_ready, 0);
    check("full_rdy1", req1_ready, 0);
    step;
    check("full_winc", fifo_winc, 0);
    check("full_wdata", fifo_wdata, 8'h57);

    // one pop frees exactly one transfer
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    fifo_rd = 1'b1;
    step;
    fifo_rd = 1'b0;
    check("pop_credit", credit, 1);
    drive(0, 8'h00, 0, 1, 8'h60, 1); #1;
    check("pop_rdy1", req1_ready, 1);
    step;
    check("pop_winc", fifo_winc, 1);
    check("pop_wdata", fifo_wdata, 8'h60);
    check("pop_credit0", credit, 0);
    #1;
    check("pop_rdy1_0", req1_ready, 0);
    step;
    check("pop_winc0", fifo_winc, 0);
    drive(0, 8'h00, 0, 0, 8'h00, 0);

    // transfer plus pop at credit 5
    fifo_rd = 1'b1;
    repeat (5) step;
    fifo_rd = 1'b0;
    check("c5_credit", credit, 5);
    drive(1, 8'h70, 1, 0, 8'h00, 0);
    fifo_rd = 1'b1;
    step;
    fifo_rd = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    check("c5_both_credit", credit, 5);
    check("c5_winc", fifo_winc, 1);
    check("c5_wdata", fifo_wdata, 8'h70);

    // reset mid-burst in LOCK1
    drive(0, 8'h00, 0, 1, 8'h80, 0);
    step;
    drive(1, 8'h90, 1, 1, 8'h81, 0); #1;
    check("l1_rdy0", req0_ready, 0);
    check("l1_rdy1", req1_ready, 1);
    step;
    check("l1_wdata", fifo_wdata, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_winc", fifo_winc, 0);
    check("mrst_credit", credit, 16);
    check("mrst_rdy0", req0_ready, 0);
    check("mrst_rdy1", req1_ready, 0);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rdy0", req0_ready, 1);
    check("post_rdy1", req1_ready, 0);
    step;
    check("post_wdata", fifo_wdata, 8'h90);
    check("post_credit", credit, 15);
    drive(0, 8'h00, 0, 0, 8'h00, 0);

    // pops at full credit saturate
    fifo_rd = 1'b1;
    step;
    check("sat_credit16", credit, 16);
    step;
    check("sat_credit", credit, 16);
    fifo_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
